base_rev_stage: RTL and testbench

//  Registered, flow-controlled reordering stage. It consumes a big-endian-indexed bus ([0:width-1]).
//  Per beat, it either passes the word through or reverses it in units of 'gran' bits.

---
 rtl/base_rev_stage.sv | 119 +++++++++++
 tb/tb_base_rev_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/base_rev_stage.sv
// Registered, flow-controlled granule-reversal stage on a [0:width-1] bus.
// A main register plus one skid register give full throughput with a registered i_r.
module base_rev_stage #(
  parameter int width = 32,
  parameter int gran  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_v,
  output logic             i_r,
  input  logic             i_rev,
  input  logic [0:width-1] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [0:width-1] o_d
);

  localparam int NGRAN = (gran > 0) ? (width / gran) : 1;

  generate
    if (gran < 1) begin : g_bad_gran
      $error("base_rev_stage: gran must be at least 1");
    end else if ((width % gran) != 0) begin : g_bad_width
      $error("base_rev_stage: width must be a multiple of gran");
    end
  endgenerate

  // Encoding chosen so o_v and skid_v are direct state-register bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [0:width-1]   main_d_r;
  logic [0:width-1]   main_d_s;
  logic [0:width-1]   skid_d_r;
  logic [0:width-1]   skid_d_s;
  logic [0:width-1]   in_word_s;
  logic               skid_v_s;
  logic               acc_s;
  logic               tak_s;

  function automatic logic [0:width-1] rev_granules(input logic [0:width-1] d);
    logic [0:width-1] r;
    r = d;
    for (int j = 0; j < NGRAN; j++) begin
      for (int b = 0; b < gran; b++) begin
        r[j*gran + b] = d[(NGRAN-1-j)*gran + b];
      end
    end
    return r;
  endfunction

  assign o_v       = state_r[0];
  assign skid_v_s  = state_r[1];
  assign o_d       = main_d_r;
  assign i_r       = reset_n & ~skid_v_s;
  assign acc_s     = i_v & i_r;
  assign tak_s     = o_v & o_r;
  assign in_word_s = i_rev ? rev_granules(i_d) : i_d;

  // Next-state and storage-update decode for the main/skid pair.
  always_comb begin
    state_s  = state_r;
    main_d_s = main_d_r;
    skid_d_s = skid_d_r;
    case (state_r)
      ST_EMPTY: begin
        if (acc_s) begin
          main_d_s = in_word_s;
          state_s  = ST_ONE;
        end else begin
          state_s  = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc_s && tak_s) begin
          main_d_s = in_word_s;
          state_s  = ST_ONE;
        end else if (acc_s) begin
          skid_d_s = in_word_s;
          state_s  = ST_FULL;
        end else if (tak_s) begin
          state_s  = ST_EMPTY;
        end else begin
          state_s  = ST_ONE;
        end
      end
      ST_FULL: begin
        if (tak_s) begin
          main_d_s = skid_d_r;
          state_s  = ST_ONE;
        end else begin
          state_s  = ST_FULL;
        end
      end
      default: begin
        state_s  = ST_EMPTY;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= ST_EMPTY;
      main_d_r <= {width{1'b0}};
      skid_d_r <= {width{1'b0}};
    end else begin
      state_r  <= state_s;
      main_d_r <= main_d_s;
      skid_d_r <= skid_d_s;
    end
  end

endmodule

// File: tb/tb_base_rev_stage.sv
// Scoreboard bench for base_rev_stage: width=16/gran=4 main instance, gran=1 side instance.
module tb_base_rev_stage;

  logic        clk;
  logic        reset_n;
  logic        i_v, i_r, i_rev, o_v, o_r;
  logic [0:15] i_d, o_d;
  logic        i_v2, i_r2, i_rev2, o_v2, o_r2;
  logic [0:15] i_d2, o_d2;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [15:0] sb_q[$];

  base_rev_stage #(.width(16), .gran(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_v(i_v), .i_r(i_r), .i_rev(i_rev), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d));

  base_rev_stage #(.width(16), .gran(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_v(i_v2), .i_r(i_r2), .i_rev(i_rev2), .i_d(i_d2),
    .o_v(o_v2), .o_r(o_r2), .o_d(o_d2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  // Independent nibble-reversal model on a conventional [15:0] view of the word.
  function automatic logic [15:0] model(input logic [15:0] d, input logic rev);
    return rev ? {d[3:0], d[7:4], d[11:8], d[15:12]} : d;
  endfunction

  // Drives one cycle starting at posedge+1; records expected response on acceptance.
  task automatic cycle(input logic v, input logic [15:0] d, input logic rev, input logic r,
                       input logic [15:0] e, output logic accepted);
    i_v = v; i_d = d; i_rev = rev; o_r = r;
    @(negedge clk);
    accepted = v & i_r;
    if (accepted) sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on each output transfer and checks hold stability under backpressure.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d     = 16'h0000;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_o_v", {15'd0, o_v}, 16'h0001);
        check("hold_o_d", o_d, prev_d);
      end
      if (o_v && o_r) begin
        n_out++;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: act=%h req=none", o_d);
        end else begin
          check("sb_data", o_d, sb_q.pop_front());
        end
      end
      prev_stall <= o_v & ~o_r;
      prev_d     <= o_d;
    end
  end

  logic        a;
  int          sent, guard, base_out;
  logic [15:0] w;
  logic        rv;

  initial begin
    reset_n = 1'b0; i_v = 1'b0; i_d = 16'h0000; i_rev = 1'b0; o_r = 1'b0;
    i_v2 = 1'b0; i_d2 = 16'h0000; i_rev2 = 1'b0; o_r2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_i_r_low", {15'd0, i_r}, 16'h0000);
    check("rst_o_v", {15'd0, o_v}, 16'h0000);
    check("rst_o_d", o_d, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_i_r", {15'd0, i_r}, 16'h0001);
    @(posedge clk); #1;

    // 1: single reversed beat
    cycle(1'b1, 16'h1234, 1'b1, 1'b1, 16'h4321, a);
    i_v = 1'b0;
    @(negedge clk);
    check("t1_o_v", {15'd0, o_v}, 16'h0001);
    check("t1_o_d", o_d, 16'h4321);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_o_v_drop", {15'd0, o_v}, 16'h0000);
    @(posedge clk); #1;

    // 2: gran=1 instance, reversed then pass-through
    i_v2 = 1'b1; i_d2 = 16'h0001; i_rev2 = 1'b1;
    @(posedge clk); #1;
    i_rev2 = 1'b0;
    @(negedge clk);
    check("t2_o_v", {15'd0, o_v2}, 16'h0001);
    check("t2_bitrev", o_d2, 16'h8000);
    @(posedge clk); #1;
    i_v2 = 1'b0;
    @(negedge clk);
    check("t2_pass", o_d2, 16'h0001);
    @(posedge clk); #1;

    // 3: backpressure fills the skid
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0, 16'hAAAA, a);
    check("t3_acc1", {15'd0, a}, 16'h0001);
    cycle(1'b1, 16'hBBBB, 1'b0, 1'b0, 16'hBBBB, a);
    check("t3_acc2", {15'd0, a}, 16'h0001);
    i_v = 1'b0;
    @(negedge clk);
    check("t3_i_r_full", {15'd0, i_r}, 16'h0000);
    check("t3_hold", o_d, 16'hAAAA);
    @(posedge clk); #1;
    o_r = 1'b1;
    @(negedge clk);
    check("t3_first", o_d, 16'hAAAA);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_second", o_d, 16'hBBBB);
    check("t3_i_r_back", {15'd0, i_r}, 16'h0001);
    @(posedge clk); #1;
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, a);

    // 4: 64 counter beats, random i_rev and o_r
    sent = 0; guard = 0;
    while (sent < 64 && guard < 2000) begin
      w  = sent[15:0];
      rv = 1'($urandom_range(0, 1));
      cycle(1'b1, w, rv, 1'($urandom_range(0, 1)), model(w, rv), a);
      if (a) sent++;
      guard++;
    end
    check("t4_sent", sent[15:0], 16'd64);
    repeat (4) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, a);
    check("t4_drained", sb_q.size() == 0 ? 16'h0001 : 16'h0000, 16'h0001);

    // 5: reset while FULL
    cycle(1'b1, 16'h1111, 1'b0, 1'b0, 16'h1111, a);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0, 16'h2222, a);
    reset_n = 1'b0; i_v = 1'b1; i_d = 16'h3333; o_r = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("t5_i_r_rst", {15'd0, i_r}, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1; i_v = 1'b0; o_r = 1'b1;
    @(negedge clk);
    check("t5_o_v", {15'd0, o_v}, 16'h0000);
    check("t5_i_r_after", {15'd0, i_r}, 16'h0001);
    @(posedge clk); #1;
    repeat (4) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, a);

    // 6: 20 back-to-back beats with o_r held high
    base_out = n_out;
    for (int k = 0; k < 20; k++) begin
      i_v = 1'b1; i_d = 16'(k * 16'h0111); i_rev = 1'b1; o_r = 1'b1;
      @(negedge clk);
      check("t6_i_r", {15'd0, i_r}, 16'h0001);
      if (k > 0) check("t6_o_v", {15'd0, o_v}, 16'h0001);
      if (i_r) sb_q.push_back(model(16'(k * 16'h0111), 1'b1));
      @(posedge clk); #1;
    end
    i_v = 1'b0;
    @(negedge clk);
    check("t6_last_v", {15'd0, o_v}, 16'h0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_end_v", {15'd0, o_v}, 16'h0000);
    check("t6_count", 16'(n_out - base_out), 16'd20);
    check("final_empty", sb_q.size() == 0 ? 16'h0001 : 16'h0000, 16'h0001);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
